// File: rtl/stream_rr_merge_pkg.sv
// Shared constants and FSM encoding for the round-robin stream merge.
package stream_rr_merge_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_N_CH  = 4;
    localparam int unsigned DEF_CW    = 2;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

endpackage

// File: rtl/stream_rr_merge_if.sv
// Bundle of the N-way input streams, merged output stream and exception flags.
interface stream_rr_merge_if
    import stream_rr_merge_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned CW    = DEF_CW
);
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_stb;
    logic [N_CH-1:0]       in_ack;
    logic [WIDTH-1:0]      out_data;
    logic [CW-1:0]         out_chan;
    logic                  out_stb;
    logic                  out_ack;
    logic [N_CH-1:0]       exception_in;
    logic                  exception;
    logic [CW-1:0]         exception_chan;

    modport master (
        output in_data, in_stb, out_ack, exception_in,
        input  in_ack, out_data, out_chan, out_stb, exception, exception_chan
    );

    modport slave (
        input  in_data, in_stb, out_ack, exception_in,
        output in_ack, out_data, out_chan, out_stb, exception, exception_chan
    );
endinterface

// File: rtl/stream_rr_merge_rr_pick.sv
// Combinational round-robin picker: first request after i_last, or only i_last when locked.
module stream_rr_merge_rr_pick #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CW   = 2
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CW-1:0]   i_last,
    input  logic            i_lock,
    output logic [CW-1:0]   o_gnt,
    output logic            o_found
);
    localparam int unsigned SW = CW + 1;

    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_rot;
    logic [SW-1:0]   w_off;
    logic [SW-1:0]   w_idx;
    logic [SW-1:0]   w_sum;

    // Rotate so the channel after i_last sits at bit 0, priority-encode, then rotate back.
    always_comb begin
        w_req   = i_lock ? (i_req & (N_CH'(1) << i_last)) : i_req;
        w_off   = SW'(i_last) + SW'(1);
        w_rot   = N_CH'({w_req, w_req} >> w_off);
        w_idx   = '0;
        o_found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_idx   = SW'(i);
                o_found = 1'b1;
            end
        end
        w_sum = w_idx + w_off;
        if (w_sum >= SW'(N_CH)) begin
            w_sum = w_sum - SW'(N_CH);
        end
        o_gnt = CW'(w_sum);
    end

endmodule

// File: rtl/stream_rr_merge.sv
// N-way round-robin merge of stb/ack streams onto one registered sink, plus sticky exception capture.
module stream_rr_merge
    import stream_rr_merge_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned N_CH     = DEF_N_CH,
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned PKT_MODE = 0
) (
    input logic              clk,
    input logic              rst,
    stream_rr_merge_if.slave bus
);
    state_t            r_state, w_state_d;
    logic [CW-1:0]     r_grant, w_grant_d;
    logic [CW-1:0]     r_last, w_last_d;
    logic              r_lock, w_lock_d;
    logic [N_CH-1:0]   r_in_ack, w_in_ack_d;
    logic [WIDTH-1:0]  r_data, w_data_d;
    logic [CW-1:0]     r_chan, w_chan_d;
    logic              r_stb, w_stb_d;
    logic              r_exc, w_exc_d;
    logic [CW-1:0]     r_exc_chan, w_exc_chan_d;

    logic [CW-1:0]     w_pick;
    logic              w_found;
    logic [WIDTH-1:0]  w_sel_data;
    logic [CW-1:0]     w_exc_idx;

    stream_rr_merge_rr_pick #(.N_CH(N_CH), .CW(CW)) u_pick (
        .i_req   (bus.in_stb),
        .i_last  (r_last),
        .i_lock  (r_lock),
        .o_gnt   (w_pick),
        .o_found (w_found)
    );

    // Data mux for the granted channel and lowest-index exception source.
    always_comb begin
        w_sel_data = '0;
        w_exc_idx  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (CW'(i) == r_grant) begin
                w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.exception_in[i]) begin
                w_exc_idx = CW'(i);
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_grant_d    = r_grant;
        w_last_d     = r_last;
        w_lock_d     = r_lock;
        w_in_ack_d   = '0;
        w_data_d     = r_data;
        w_chan_d     = r_chan;
        w_stb_d      = r_stb;
        w_exc_d      = r_exc | (|bus.exception_in);
        w_exc_chan_d = (!r_exc && (|bus.exception_in)) ? w_exc_idx : r_exc_chan;

        case (r_state)
            ST_ARB: begin
                if (w_found) begin
                    w_grant_d  = w_pick;
                    w_in_ack_d = N_CH'(1) << w_pick;
                    w_state_d  = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                // A source that dropped stb while acked forfeits the slot without moving priority.
                if (bus.in_stb[r_grant]) begin
                    w_data_d  = w_sel_data;
                    w_chan_d  = r_grant;
                    w_last_d  = r_grant;
                    w_stb_d   = 1'b1;
                    w_state_d = ST_SEND;
                end else begin
                    w_state_d = ST_ARB;
                end
            end
            ST_SEND: begin
                if (bus.out_ack) begin
                    w_stb_d   = 1'b0;
                    w_lock_d  = (PKT_MODE != 0) ? ~r_data[WIDTH-1] : 1'b0;
                    w_state_d = ST_ARB;
                end
            end
            default: begin
                w_state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ARB;
            r_grant    <= '0;
            r_last     <= CW'(N_CH - 1);
            r_lock     <= 1'b0;
            r_in_ack   <= '0;
            r_data     <= '0;
            r_chan     <= '0;
            r_stb      <= 1'b0;
            r_exc      <= 1'b0;
            r_exc_chan <= '0;
        end else begin
            r_state    <= w_state_d;
            r_grant    <= w_grant_d;
            r_last     <= w_last_d;
            r_lock     <= w_lock_d;
            r_in_ack   <= w_in_ack_d;
            r_data     <= w_data_d;
            r_chan     <= w_chan_d;
            r_stb      <= w_stb_d;
            r_exc      <= w_exc_d;
            r_exc_chan <= w_exc_chan_d;
        end
    end

    assign bus.in_ack         = r_in_ack;
    assign bus.out_data       = r_data;
    assign bus.out_chan       = r_chan;
    assign bus.out_stb        = r_stb;
    assign bus.exception      = r_exc;
    assign bus.exception_chan = r_exc_chan;

endmodule
